// File: rtl/perip_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// perip_bus_arbiter_pkg
// Shared definitions for the peripheral register-port arbiter:
//   - default address / data widths of the register bus
//   - master ID encodings used by the picker and the response tag pipe
//   - arbiter FSM state encodings
//   - helper that maps an FSM state to the set of masters allowed to win
// ---------------------------------------------------------------------------
package perip_bus_arbiter_pkg;

    localparam int unsigned INST_ADDR_BUS = 32;
    localparam int unsigned INST_REG_DATA = 32;

    localparam logic MST_M0 = 1'b0;
    localparam logic MST_M1 = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_e;

    // While a master holds the lock only that master may be granted.
    function automatic logic [1:0] lock_allow(input arb_state_e state);
        logic [1:0] allow;
        case (state)
            ARB_LOCK0: allow = 2'b01;
            ARB_LOCK1: allow = 2'b10;
            default:   allow = 2'b11;
        endcase
        return allow;
    endfunction

endpackage

// File: rtl/perip_bus_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// perip_rr_pick
// Two-way combinational grant picker.
// Ports:
//   req[1:0]   requests from m0 (bit 0) and m1 (bit 1)
//   last       master granted most recently (round-robin pointer)
//   prio_m0    1: m0 wins every conflict
//   allow[1:0] masters currently permitted to win
//   gnt[1:0]   one-hot grant (all zero when nobody eligible)
//   winner     ID of the granted master (MST_M0 when no grant)
// ---------------------------------------------------------------------------
module perip_rr_pick
    import perip_bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       prio_m0,
    input  logic [1:0] allow,
    output logic [1:0] gnt,
    output logic       winner
);

    logic [1:0] eligible;

    // On a conflict the master that was not granted last wins, unless m0
    // has fixed priority.
    always_comb begin
        eligible = req & allow;
        gnt      = 2'b00;
        winner   = MST_M0;
        case (eligible)
            2'b01: begin
                gnt    = 2'b01;
                winner = MST_M0;
            end
            2'b10: begin
                gnt    = 2'b10;
                winner = MST_M1;
            end
            2'b11: begin
                if (prio_m0 || (last == MST_M1)) begin
                    gnt    = 2'b01;
                    winner = MST_M0;
                end else begin
                    gnt    = 2'b10;
                    winner = MST_M1;
                end
            end
            default: begin
                gnt    = 2'b00;
                winner = MST_M0;
            end
        endcase
    end

endmodule

// File: rtl/perip_bus_arbiter.sv
// ---------------------------------------------------------------------------
// perip_bus_arbiter
// Shares one registered peripheral register port between m0 (core LSU) and
// m1 (debug / boot loader). Round-robin or fixed-m0 arbitration, per-master
// lock for atomic read-modify-write, lock force-release after MAX_LOCK
// granted cycles when the other master is waiting.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mX_req_i/we_i/lock_i       request, write select, keep-ownership
//   mX_addr_i/wdata_i          access address and write data
//   mX_gnt_o                   combinational accept for this cycle
//   mX_rvalid_o/rdata_o        read response, two cycles after the grant
//   wr_en_o/wr_addr_o/wr_data_o registered slave write port
//   rd_addr_o                  registered slave read address
//   rd_data_i                  slave read data, one cycle after rd_addr_o
// ---------------------------------------------------------------------------
module perip_bus_arbiter
    import perip_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = INST_ADDR_BUS,
    parameter int unsigned DATA_W      = INST_REG_DATA,
    parameter bit          M0_PRIORITY = 1'b0,
    parameter int unsigned MAX_LOCK    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic              m0_lock_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic              m1_lock_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i
);

    // One spare bit so the incremented count can exceed MAX_LOCK without
    // wrapping when the counter is saturated.
    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1) + 1;
    localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(MAX_LOCK);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [1:0]        tag_vld_q, tag_vld_d;
    logic [1:0]        tag_own_q, tag_own_d;

    logic [1:0]        gnt;
    logic              winner;
    logic              any_gnt;
    logic              sel_we;
    logic              sel_lock;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              other_req;
    logic [CNT_W-1:0]  lock_cnt_inc;

    perip_rr_pick u_pick (
        .req     ({m1_req_i, m0_req_i}),
        .last    (last_q),
        .prio_m0 (M0_PRIORITY),
        .allow   (lock_allow(state_q)),
        .gnt     (gnt),
        .winner  (winner)
    );

    // Steer the winning master's access fields onto the slave-port inputs.
    always_comb begin
        any_gnt      = |gnt;
        sel_we       = (winner == MST_M1) ? m1_we_i    : m0_we_i;
        sel_lock     = (winner == MST_M1) ? m1_lock_i  : m0_lock_i;
        sel_addr     = (winner == MST_M1) ? m1_addr_i  : m0_addr_i;
        sel_wdata    = (winner == MST_M1) ? m1_wdata_i : m0_wdata_i;
        other_req    = (state_q == ARB_LOCK1) ? m0_req_i : m1_req_i;
        lock_cnt_inc = lock_cnt_q + CNT_ONE;
    end

    // Next-state logic: slave-port capture, response tag pipe, RR pointer
    // and lock FSM with its granted-cycle counter. The counter includes the
    // grant that acquired the lock, so MAX_LOCK bounds the locked grants.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        lock_cnt_d = lock_cnt_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_addr_d  = rd_addr_q;
        tag_vld_d  = {tag_vld_q[0], any_gnt & ~sel_we};
        tag_own_d  = {tag_own_q[0], winner};

        if (any_gnt) begin
            last_d = winner;
            if (sel_we) begin
                wr_en_d   = 1'b1;
                wr_addr_d = sel_addr;
                wr_data_d = sel_wdata;
            end else begin
                rd_addr_d = sel_addr;
            end
        end

        case (state_q)
            ARB_IDLE: begin
                if (any_gnt && sel_lock) begin
                    state_d    = (winner == MST_M1) ? ARB_LOCK1 : ARB_LOCK0;
                    lock_cnt_d = CNT_ONE;
                end
            end
            ARB_LOCK0, ARB_LOCK1: begin
                if (any_gnt) begin
                    if (!sel_lock) begin
                        state_d    = ARB_IDLE;
                        lock_cnt_d = '0;
                    end else if (lock_cnt_inc >= LOCK_LIMIT) begin
                        // Saturate while nobody else is waiting.
                        if (other_req) begin
                            state_d    = ARB_IDLE;
                            lock_cnt_d = '0;
                        end else begin
                            lock_cnt_d = LOCK_LIMIT;
                        end
                    end else begin
                        lock_cnt_d = lock_cnt_inc;
                    end
                end
            end
            default: begin
                state_d    = ARB_IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    // All state resets asynchronously; the RR pointer resets to "m1 was
    // last" so m0 wins the first conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            last_q     <= MST_M1;
            lock_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_addr_q  <= '0;
            tag_vld_q  <= 2'b00;
            tag_own_q  <= 2'b00;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_addr_q  <= rd_addr_d;
            tag_vld_q  <= tag_vld_d;
            tag_own_q  <= tag_own_d;
        end
    end

    assign m0_gnt_o  = gnt[0];
    assign m1_gnt_o  = gnt[1];
    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign rd_addr_o = rd_addr_q;

    // Read data is only forwarded to the owner of the response in flight.
    assign m0_rvalid_o = tag_vld_q[1] & (tag_own_q[1] == MST_M0);
    assign m1_rvalid_o = tag_vld_q[1] & (tag_own_q[1] == MST_M1);
    assign m0_rdata_o  = m0_rvalid_o ? rd_data_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? rd_data_i : '0;

endmodule

// File: tb/tb_perip_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_perip_bus_arbiter
// Directed bench for perip_bus_arbiter with a small register-file slave.
// A second instance with fixed m0 priority shares the master inputs.
// ---------------------------------------------------------------------------
module tb_perip_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m0_lock;
    logic [31:0] m0_addr, m0_wdata;
    logic        m1_req, m1_we, m1_lock;
    logic [31:0] m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        wr_en;
    logic [31:0] wr_addr, wr_data, rd_addr, rd_data;

    logic        p_m0_gnt, p_m0_rvalid, p_m1_gnt, p_m1_rvalid, p_wr_en;
    logic [31:0] p_m0_rdata, p_m1_rdata, p_wr_addr, p_wr_data, p_rd_addr;

    logic        slave_load;
    logic [31:0] slave_mem [0:7];

    int check_count;
    int error_count;

    perip_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .M0_PRIORITY(1'b0), .MAX_LOCK(16)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_lock_i(m0_lock),
        .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_lock_i(m1_lock),
        .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .rd_addr_o(rd_addr), .rd_data_i(rd_data)
    );

    perip_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .M0_PRIORITY(1'b1), .MAX_LOCK(16)
    ) u_dut_prio (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_lock_i(m0_lock),
        .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(p_m0_gnt), .m0_rvalid_o(p_m0_rvalid), .m0_rdata_o(p_m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_lock_i(m1_lock),
        .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_gnt_o(p_m1_gnt), .m1_rvalid_o(p_m1_rvalid), .m1_rdata_o(p_m1_rdata),
        .wr_en_o(p_wr_en), .wr_addr_o(p_wr_addr), .wr_data_o(p_wr_data),
        .rd_addr_o(p_rd_addr), .rd_data_i(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file slave: writes at the end of the wr_en cycle, returns
    // rd_data one cycle after sampling rd_addr.
    always @(posedge clk) begin
        if (slave_load) begin
            slave_mem[0] <= 32'h0000_00A5;
            slave_mem[1] <= 32'h0000_1234;
            for (int i = 2; i < 8; i++) slave_mem[i] <= 32'h0;
        end else if (wr_en) begin
            slave_mem[wr_addr[4:2]] <= wr_data;
        end
        rd_data <= slave_mem[rd_addr[4:2]];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(
        input logic r0, input logic w0, input logic l0, input logic [31:0] a0, input logic [31:0] d0,
        input logic r1, input logic w1, input logic l1, input logic [31:0] a1, input logic [31:0] d1);
        m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    initial begin
        check_count = 0;
        error_count = 0;
        rst_n       = 1'b0;
        slave_load  = 1'b1;
        rd_data     = 32'h0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        nextCycle();
        nextCycle();
        #1;
        checkOutput("rst_m0_gnt", {31'h0, m0_gnt}, 32'h0);
        checkOutput("rst_wr_en", {31'h0, wr_en}, 32'h0);
        checkOutput("rst_rd_addr", rd_addr, 32'h0);
        checkOutput("rst_m0_rvalid", {31'h0, m0_rvalid}, 32'h0);
        checkOutput("rst_m1_rvalid", {31'h0, m1_rvalid}, 32'h0);
        nextCycle();
        rst_n      = 1'b1;
        slave_load = 1'b0;

        // Single m0 write
        $display("[TB] single m0 write");
        nextCycle();
        applyStimulus(1, 1, 0, 32'h08, 32'h64, 0, 0, 0, 0, 0);
        #1;
        checkOutput("wr_m0_gnt", {31'h0, m0_gnt}, 32'h1);
        checkOutput("wr_m1_gnt", {31'h0, m1_gnt}, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("wr_en_t1", {31'h0, wr_en}, 32'h1);
        checkOutput("wr_addr_t1", wr_addr, 32'h08);
        checkOutput("wr_data_t1", wr_data, 32'h64);
        nextCycle();
        #1;
        checkOutput("wr_en_t2", {31'h0, wr_en}, 32'h0);
        checkOutput("wr_m0_rvalid_t2", {31'h0, m0_rvalid}, 32'h0);

        // m1 read of 0x04
        $display("[TB] m1 read");
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 32'h04, 0);
        #1;
        checkOutput("rd_m1_gnt", {31'h0, m1_gnt}, 32'h1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("rd_addr_t1", rd_addr, 32'h04);
        checkOutput("rd_wr_en_t1", {31'h0, wr_en}, 32'h0);
        nextCycle();
        #1;
        checkOutput("rd_m1_rvalid_t2", {31'h0, m1_rvalid}, 32'h1);
        checkOutput("rd_m1_rdata_t2", m1_rdata, 32'h1234);
        checkOutput("rd_m0_rvalid_t2", {31'h0, m0_rvalid}, 32'h0);

        // Both masters read every cycle: grants alternate, responses follow
        $display("[TB] round robin reads");
        for (int k = 0; k < 6; k++) begin
            nextCycle();
            if (k < 4) applyStimulus(1, 0, 0, 32'h08, 0, 1, 0, 0, 32'h04, 0);
            else       applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            if (k < 4) begin
                checkOutput($sformatf("rr_m0_gnt_%0d", k), {31'h0, m0_gnt}, {31'h0, (k % 2) == 0});
                checkOutput($sformatf("rr_m1_gnt_%0d", k), {31'h0, m1_gnt}, {31'h0, (k % 2) == 1});
                checkOutput($sformatf("prio_m0_gnt_%0d", k), {31'h0, p_m0_gnt}, 32'h1);
                checkOutput($sformatf("prio_m1_gnt_%0d", k), {31'h0, p_m1_gnt}, 32'h0);
            end
            if (k >= 2) begin
                checkOutput($sformatf("rr_m0_rvalid_%0d", k), {31'h0, m0_rvalid}, {31'h0, (k % 2) == 0});
                checkOutput($sformatf("rr_m1_rvalid_%0d", k), {31'h0, m1_rvalid}, {31'h0, (k % 2) == 1});
                if ((k % 2) == 0) checkOutput($sformatf("rr_m0_rdata_%0d", k), m0_rdata, 32'h64);
                else              checkOutput($sformatf("rr_m1_rdata_%0d", k), m1_rdata, 32'h1234);
            end
        end

        // m0 locked read-modify-write of 0x00 with m1 waiting
        $display("[TB] locked rmw");
        nextCycle();
        applyStimulus(1, 0, 1, 32'h00, 0, 1, 0, 0, 32'h00, 0);
        #1;
        checkOutput("lk_a_m0_gnt", {31'h0, m0_gnt}, 32'h1);
        checkOutput("lk_a_m1_gnt", {31'h0, m1_gnt}, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 32'h00, 0);
        #1;
        checkOutput("lk_b_m0_gnt", {31'h0, m0_gnt}, 32'h0);
        checkOutput("lk_b_m1_gnt", {31'h0, m1_gnt}, 32'h0);
        nextCycle();
        applyStimulus(1, 1, 0, 32'h00, 32'h55, 1, 0, 0, 32'h00, 0);
        #1;
        checkOutput("lk_c_m0_gnt", {31'h0, m0_gnt}, 32'h1);
        checkOutput("lk_c_m1_gnt", {31'h0, m1_gnt}, 32'h0);
        checkOutput("lk_c_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
        checkOutput("lk_c_m0_rdata", m0_rdata, 32'hA5);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 32'h00, 0);
        #1;
        checkOutput("lk_d_m1_gnt", {31'h0, m1_gnt}, 32'h1);
        checkOutput("lk_d_wr_en", {31'h0, wr_en}, 32'h1);
        checkOutput("lk_d_wr_data", wr_data, 32'h55);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("lk_e_wr_en", {31'h0, wr_en}, 32'h0);
        nextCycle();
        #1;
        checkOutput("lk_f_m1_rvalid", {31'h0, m1_rvalid}, 32'h1);
        checkOutput("lk_f_m1_rdata", m1_rdata, 32'h55);

        // Lock held for 20 grants: force release after 16 locked grants
        $display("[TB] lock force release");
        for (int k = 0; k <= 20; k++) begin
            nextCycle();
            applyStimulus(1, 0, 1, 32'h08, 0, (k <= 16), 0, 0, 32'h04, 0);
            #1;
            checkOutput($sformatf("ml_m0_gnt_%0d", k), {31'h0, m0_gnt}, {31'h0, k != 16});
            checkOutput($sformatf("ml_m1_gnt_%0d", k), {31'h0, m1_gnt}, {31'h0, k == 16});
            if (k == 18) begin
                checkOutput("ml_m1_rvalid", {31'h0, m1_rvalid}, 32'h1);
                checkOutput("ml_m1_rdata", m1_rdata, 32'h1234);
            end
        end

        // Release lock, m1 read, then reset in the following cycle
        $display("[TB] reset mid-operation");
        nextCycle();
        applyStimulus(1, 1, 0, 32'h0C, 32'h77, 0, 0, 0, 0, 0);
        #1;
        checkOutput("rs_r0_m0_gnt", {31'h0, m0_gnt}, 32'h1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 32'h04, 0);
        #1;
        checkOutput("rs_r1_m1_gnt", {31'h0, m1_gnt}, 32'h1);
        checkOutput("rs_r1_wr_addr", wr_addr, 32'h0C);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("rs_m0_gnt", {31'h0, m0_gnt}, 32'h0);
        checkOutput("rs_m1_gnt", {31'h0, m1_gnt}, 32'h0);
        checkOutput("rs_wr_en", {31'h0, wr_en}, 32'h0);
        checkOutput("rs_wr_addr", wr_addr, 32'h0);
        checkOutput("rs_wr_data", wr_data, 32'h0);
        checkOutput("rs_rd_addr", rd_addr, 32'h0);
        checkOutput("rs_m0_rvalid", {31'h0, m0_rvalid}, 32'h0);
        checkOutput("rs_m1_rvalid", {31'h0, m1_rvalid}, 32'h0);
        checkOutput("rs_m0_rdata", m0_rdata, 32'h0);
        checkOutput("rs_m1_rdata", m1_rdata, 32'h0);
        nextCycle();
        #1;
        checkOutput("rs_hold_m1_rvalid", {31'h0, m1_rvalid}, 32'h0);
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(1, 0, 0, 32'h08, 0, 1, 0, 0, 32'h04, 0);
        #1;
        checkOutput("rs_p0_m0_gnt", {31'h0, m0_gnt}, 32'h1);
        checkOutput("rs_p0_m1_gnt", {31'h0, m1_gnt}, 32'h0);
        checkOutput("rs_p0_m1_rvalid", {31'h0, m1_rvalid}, 32'h0);

        // A registered write is cancelled by reset before its clock edge
        nextCycle();
        applyStimulus(1, 1, 0, 32'h08, 32'h99, 0, 0, 0, 0, 0);
        #1;
        checkOutput("cx_p1_m0_gnt", {31'h0, m0_gnt}, 32'h1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("cx_p2_wr_en", {31'h0, wr_en}, 32'h1);
        checkOutput("cx_p2_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
        checkOutput("cx_p2_m0_rdata", m0_rdata, 32'h64);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("cx_rst_wr_en", {31'h0, wr_en}, 32'h0);
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(1, 0, 0, 32'h08, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("cx_p3_m0_gnt", {31'h0, m0_gnt}, 32'h1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("cx_p4_rd_addr", rd_addr, 32'h08);
        nextCycle();
        #1;
        checkOutput("cx_p5_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
        checkOutput("cx_p5_m0_rdata", m0_rdata, 32'h64);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
